// File: rtl/led_seq_monitor.sv
`default_nettype none
// led_seq_monitor: passive observer of the sequencer LED bus; checks that each new
// value is a one-place rotation of the last and reports lock, errors, stalls and fault.
module led_seq_monitor #(
  parameter int WIDTH   = 8,
  parameter int DIR     = 0,
  parameter int MAX_ERR = 3,
  parameter int TIMEOUT = 200000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] led_in,
  output logic             locked,
  output logic             err,
  output logic             stall,
  output logic             fault,
  output logic [7:0]       err_count,
  output logic [15:0]      step_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, FAULT = 2'd2} state_t;

  localparam logic [31:0] STALL_LAST = 32'(TIMEOUT - 1);
  localparam logic [7:0]  ERR_LIMIT  = 8'(MAX_ERR);

  state_t           state, state_n;
  logic [WIDTH-1:0] led_q;
  logic [WIDTH-1:0] exp_q, exp_n;
  logic [7:0]       consec, consec_n;
  logic [31:0]      stall_cnt, stall_cnt_n;
  logic             err_n, stall_n;
  logic [7:0]       err_count_n;
  logic [15:0]      step_count_n;
  logic             chg, onehot, is_err;

  function automatic logic [WIDTH-1:0] rot(input logic [WIDTH-1:0] x);
    if (DIR == 0) return {x[WIDTH-2:0], x[WIDTH-1]};
    else          return {x[0], x[WIDTH-1:1]};
  endfunction

  assign chg    = (led_in != led_q);
  assign onehot = (led_in != '0) && ((led_in & (led_in - 1'b1)) == '0);

  always_comb begin
    state_n      = state;
    exp_n        = exp_q;
    consec_n     = consec;
    stall_cnt_n  = stall_cnt;
    err_n        = 1'b0;
    stall_n      = 1'b0;
    err_count_n  = err_count;
    step_count_n = step_count;
    is_err       = 1'b0;
    if (clr) begin
      state_n      = IDLE;
      exp_n        = '0;
      consec_n     = '0;
      stall_cnt_n  = '0;
      err_count_n  = '0;
      step_count_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (onehot) begin
            exp_n       = rot(led_in);
            state_n     = TRACK;
            consec_n    = '0;
            stall_cnt_n = '0;
          end
        end
        TRACK: begin
          if (chg) begin
            stall_cnt_n = '0;
            if (led_in == exp_q) begin
              step_count_n = step_count + 16'd1;
              exp_n        = rot(led_in);
              consec_n     = '0;
            end else begin
              is_err = 1'b1;
              if (onehot) exp_n = rot(led_in);
            end
          end else if (stall_cnt == STALL_LAST) begin
            stall_cnt_n = '0;
            stall_n     = 1'b1;
            is_err      = 1'b1;
          end else begin
            stall_cnt_n = stall_cnt + 32'd1;
          end
          // Bad steps and stalls share the counting and the escalation to FAULT.
          if (is_err) begin
            err_n       = 1'b1;
            err_count_n = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
            consec_n    = consec + 8'd1;
            if (consec_n >= ERR_LIMIT) state_n = FAULT;
          end
        end
        FAULT: ;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      led_q      <= '0;
      exp_q      <= '0;
      consec     <= '0;
      stall_cnt  <= '0;
      err        <= 1'b0;
      stall      <= 1'b0;
      err_count  <= '0;
      step_count <= '0;
    end else begin
      state      <= state_n;
      led_q      <= led_in;
      exp_q      <= exp_n;
      consec     <= consec_n;
      stall_cnt  <= stall_cnt_n;
      err        <= err_n;
      stall      <= stall_n;
      err_count  <= err_count_n;
      step_count <= step_count_n;
    end
  end

  assign locked = (state == TRACK);
  assign fault  = (state == FAULT);

endmodule
`default_nettype wire

// File: tb/tb_led_seq_monitor.sv
`default_nettype none
// tb_led_seq_monitor: directed stimulus, behavioural reference model compared every
// cycle, plus hand-computed literal checkpoints.
module tb_led_seq_monitor;

  localparam int TIMEOUT = 20;
  localparam int MAX_ERR = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic [7:0]  led_in = 8'h00;
  logic        locked, err, stall, fault;
  logic [7:0]  err_count;
  logic [15:0] step_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  led_seq_monitor #(.WIDTH(8), .DIR(0), .MAX_ERR(MAX_ERR), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .clr(clr), .led_in(led_in),
    .locked(locked), .err(err), .stall(stall), .fault(fault),
    .err_count(err_count), .step_count(step_count)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 = waiting for lock, 1 = tracking, 2 = faulted.
  int       m_mode = 0, m_consec = 0, m_idle = 0, m_errc = 0, m_steps = 0;
  bit [7:0] m_prev = 0, m_exp = 0;
  bit       m_err = 0, m_stall = 0;

  function automatic bit [7:0] rotl(input bit [7:0] x);
    return 8'((x << 1) | (x >> 7));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_consec = 0; m_idle = 0; m_errc = 0; m_steps = 0;
      m_prev = 0; m_exp = 0; m_err = 0; m_stall = 0;
    end else begin
      bit bad;
      bad = 0; m_err = 0; m_stall = 0;
      if (clr) begin
        m_mode = 0; m_consec = 0; m_idle = 0; m_errc = 0; m_steps = 0; m_exp = 0;
      end else if (m_mode == 0) begin
        if ($countones(led_in) == 1) begin
          m_exp = rotl(led_in); m_mode = 1; m_consec = 0; m_idle = 0;
        end
      end else if (m_mode == 1) begin
        if (led_in != m_prev) begin
          m_idle = 0;
          if (led_in == m_exp) begin
            m_steps = (m_steps + 1) % 65536; m_exp = rotl(led_in); m_consec = 0;
          end else begin
            bad = 1;
            if ($countones(led_in) == 1) m_exp = rotl(led_in);
          end
        end else begin
          m_idle = m_idle + 1;
          if (m_idle == TIMEOUT) begin
            m_idle = 0; m_stall = 1; bad = 1;
          end
        end
        if (bad) begin
          m_err = 1;
          m_errc = (m_errc < 255) ? m_errc + 1 : 255;
          m_consec = m_consec + 1;
          if (m_consec >= MAX_ERR) m_mode = 2;
        end
      end
      m_prev = led_in;
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking && rst === 1'b1) begin
      check("cyc_locked", locked, m_mode == 1);
      check("cyc_fault", fault, m_mode == 2);
      check("cyc_err", err, m_err);
      check("cyc_stall", stall, m_stall);
      check("cyc_err_count", err_count, m_errc);
      check("cyc_step_count", step_count, m_steps);
    end
  end

  task automatic hold(input logic [7:0] v, input int n);
    led_in = v;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_locked", locked, 0);
    check("reset_err_count", err_count, 0);
    check("reset_step_count", step_count, 0);
    rst = 1'b1;
    checking = 1'b1;

    // Lock and three correct steps
    hold(8'h01, 1);
    check("lock_after_first", locked, 1);
    hold(8'h01, 4);
    hold(8'h02, 5); hold(8'h04, 5); hold(8'h08, 5);
    check("lock_steps", step_count, 3);
    check("lock_no_err", err_count, 0);

    // Wrap-around 0x80 -> 0x01
    hold(8'h10, 2); hold(8'h20, 2); hold(8'h40, 2); hold(8'h80, 2);
    hold(8'h01, 2);
    check("wrap_steps", step_count, 8);
    check("wrap_no_err", err_count, 0);

    // Bad step with resync
    hold(8'h02, 2); hold(8'h04, 2);
    hold(8'h20, 1);
    check("bad_err_pulse", err, 1);
    check("bad_err_count", err_count, 1);
    hold(8'h20, 1);
    check("bad_err_single", err, 0);
    hold(8'h40, 2);
    check("resync_step", step_count, 11);

    // Stall timeouts
    hold(8'h80, 1);
    hold(8'h80, 19);
    check("stall_not_early", err_count, 1);
    hold(8'h80, 1);
    check("stall_err", err, 1);
    check("stall_pulse", stall, 1);
    check("stall_err_count", err_count, 2);
    hold(8'h80, 20);
    check("stall_second", stall, 1);
    check("stall_second_count", err_count, 3);
    hold(8'h01, 1);
    check("stall_then_step", step_count, 13);
    check("stall_still_locked", locked, 1);

    // Clear, relock, then three bad values into FAULT
    clr = 1'b1;
    hold(8'h01, 1);
    clr = 1'b0;
    check("clr_locked", locked, 0);
    check("clr_err_count", err_count, 0);
    check("clr_step_count", step_count, 0);
    hold(8'h01, 1);
    check("relock", locked, 1);
    hold(8'hFF, 1); hold(8'h00, 1); hold(8'hA0, 1);
    check("fault_set", fault, 1);
    check("fault_unlocked", locked, 0);
    check("fault_err_pulse", err, 1);
    check("fault_err_count", err_count, 3);
    hold(8'h01, 2); hold(8'h02, 2);
    check("fault_frozen", err_count, 3);
    check("fault_sticky", fault, 1);
    clr = 1'b1;
    hold(8'h02, 1);
    clr = 1'b0;
    check("fault_clr", fault, 0);
    check("fault_clr_count", err_count, 0);

    // Asynchronous reset mid-TRACK
    hold(8'h02, 1);
    hold(8'h04, 2); hold(8'h08, 2);
    hold(8'hFF, 1);
    hold(8'h10, 2);
    check("pre_rst_steps", step_count, 3);
    check("pre_rst_errs", err_count, 1);
    #1 rst = 1'b0;
    #1;
    check("async_locked", locked, 0);
    check("async_step_count", step_count, 0);
    check("async_err_count", err_count, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    hold(8'h20, 1);
    check("relock_after_rst", locked, 1);
    hold(8'h40, 2);
    check("step_after_rst", step_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_seq_monitor.md
Name: led_seq_monitor

Overview:
- Receiving end of the sequencer's 8-bit LED bus: watches the pattern stream driven by the sequencer top level and checks that each new value is the one-bit rotation of the previous value.
- Reports lock status, per-event error pulses, a saturating error count, a step count and a sticky fault.
- Sits beside the sequencer in the top level, or in the bench, as a self-checking observer; it never drives the LED bus.

Parameters:
- WIDTH, 8: LED bus width.
- DIR, 0: expected rotation direction; 0 = rotate left (bit7 wraps to bit0), 1 = rotate right.
- MAX_ERR, 3: number of consecutive errors that forces FAULT.
- TIMEOUT, 200000000: cycles without any bus change before a stall error is raised; benches override this to 20.

Ports:
- clk, input, 1: system clock; all state changes on its rising edge.
- rst, input, 1: asynchronous, active-low reset.
- clr, input, 1: synchronous clear; returns to IDLE and zeroes all counters.
- led_in, input, WIDTH: sequencer LED bus, same clock domain as clk.
- locked, output, 1: high while in TRACK.
- err, output, 1: one-cycle pulse per detected error.
- stall, output, 1: one-cycle pulse when the error is a timeout.
- fault, output, 1: sticky; high while in FAULT.
- err_count, output, 8: total errors since clear; saturates at 255.
- step_count, output, 16: correct steps since lock; wraps 65535 to 0.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; locked, err, stall and fault = 0.
  - err_count and step_count = 0.
  - led_q = 0, exp = 0, consec = 0, stall_cnt = 0.
- All outputs are registered. A decision based on the led_in value sampled at edge N is visible right after edge N.
- Definitions:
  - led_q holds the previous cycle's led_in.
  - chg = (led_in != led_q).
  - onehot = exactly one bit of led_in set.
  - rot(x) = x rotated one place in direction DIR.
- clr has highest priority after rst. It produces the reset values except led_q, which keeps sampling.
- IDLE:
  - If onehot: set exp = rot(led_in), go to TRACK, set locked = 1, clear consec and stall_cnt.
  - Non-onehot values are ignored. No errors are raised in IDLE.
- TRACK, when chg = 1 and led_in == exp (correct step):
  - step_count += 1; exp = rot(led_in); consec = 0; stall_cnt = 0.
- TRACK, when chg = 1 and led_in != exp (bad step):
  - err = 1 for one cycle; err_count += 1 (saturating); consec += 1; stall_cnt = 0.
  - If led_in is onehot, resync with exp = rot(led_in); otherwise exp is unchanged.
- TRACK, when chg = 0:
  - stall_cnt += 1.
  - When stall_cnt reaches TIMEOUT-1 on this cycle: err = 1, stall = 1, err_count += 1, consec += 1, stall_cnt = 0.
- Entering FAULT: if consec reaches MAX_ERR as a result of an error, go to FAULT on the same edge. Set fault = 1 and locked = 0. The err pulse for that error is still issued.
- FAULT:
  - Counters freeze and no further err pulses are issued.
  - Only clr or rst leaves FAULT; both lead to IDLE.
- Simultaneous events:
  - chg and stall timeout on the same cycle: chg wins and no stall is raised.
  - clr and an error on the same cycle: clr wins and there is no err pulse.
- Width rules:
  - err_count holds at 255.
  - step_count wraps.
  - stall_cnt is 32 bits and compares against TIMEOUT-1.
- Reset during TRACK or FAULT: immediate return to reset values, regardless of clk.

Test Plan:
1. Reset and lock (TIMEOUT=20): release rst, drive 00000001, then 00000010, 00000100, 00001000, each held 5 cycles -> locked=1 one edge after the first value; step_count=3; err never asserted.
2. Wrap-around (DIR=0): after lock, drive 10000000 then 00000001 -> counted as a correct step; step_count increments and err stays 0.
3. Bad step with resync: locked on 00000100, drive 00100000 -> one-cycle err; err_count=1; next value 01000000 is accepted, step_count increments and consec returns to 0.
4. Stall: locked, hold led_in constant for 20 cycles -> err and stall pulse together on the 20th cycle; err_count=1; another stall follows after 20 more cycles.
5. Fault: three consecutive bad values, e.g. 11111111, 00000000, 10100000 -> fault=1 and locked=0 on the third error; err_count=3; further changes do not change the counts. Asserting clr for one cycle gives the IDLE state with fault=0 and counts 0.
6. Asynchronous reset mid-TRACK: pull rst low between clock edges -> locked, step_count and err_count go to 0 immediately, before the next edge; after release, a onehot value locks again.
